// File: rtl/sram_req_queue_pkg.sv
// Shared SRAM request definitions for the cache/scratchpad controllers.
// Default macro geometry and the request bundle handed to sram_req_queue.
package sram_req_queue_pkg;

    localparam int SRAM_ADDR_W = 9;
    localparam int SRAM_DATA_W = 64;
    localparam int SRAM_MASK_W = SRAM_DATA_W / 8;

    typedef struct packed {
        logic                   write;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
        logic [SRAM_MASK_W-1:0] mask;
    } sram_req_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Read-response buffer: DEPTH entries, circular, storage left unreset.
// Pointers wrap by compare-and-clear so DEPTH need not be a power of two.
module sram_resp_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    parameter int PW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sram_req_queue.sv
// Request front-end for a 1R1W byte-masked SRAM macro with 1-cycle reads.
// Reads return in order on a backpressured response stream.
module sram_req_queue
    import sram_req_queue_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int MASK_W = SRAM_MASK_W,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic              io_req_bits_write,
    input  logic [ADDR_W-1:0] io_req_bits_addr,
    input  logic [DATA_W-1:0] io_req_bits_data,
    input  logic [MASK_W-1:0] io_req_bits_mask,
    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [DATA_W-1:0] io_resp_bits_data,
    output logic              io_busy,
    output logic              sram_W0_en,
    output logic [ADDR_W-1:0] sram_W0_addr,
    output logic [DATA_W-1:0] sram_W0_data,
    output logic [MASK_W-1:0] sram_W0_mask,
    output logic              sram_R0_en,
    output logic [ADDR_W-1:0] sram_R0_addr,
    input  logic [DATA_W-1:0] sram_R0_data
);

    localparam int CW = $clog2(DEPTH + 1);

    logic              inflight;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic [DATA_W-1:0] head;
    logic              buffered;
    logic              fire;
    logic              push;
    logic              pop;

    // Credit covers both the beat in flight and every buffered beat.
    assign buffered     = (count != '0);
    assign occ          = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign io_req_ready = !reset && (occ < (CW + 1)'(DEPTH));
    assign fire         = io_req_valid && io_req_ready;

    assign sram_W0_en   = fire && io_req_bits_write;
    assign sram_W0_addr = io_req_bits_addr;
    assign sram_W0_data = io_req_bits_data;
    assign sram_W0_mask = io_req_bits_mask;
    assign sram_R0_en   = fire && !io_req_bits_write;
    assign sram_R0_addr = io_req_bits_addr;

    always_ff @(posedge clock) begin
        if (reset)
            inflight <= 1'b0;
        else
            inflight <= sram_R0_en;
    end

    // Empty buffer: flow through; otherwise the returning beat queues behind the head.
    assign push = inflight && (buffered || !io_resp_ready);
    assign pop  = buffered && io_resp_ready;

    assign io_resp_valid     = !reset && (inflight || buffered);
    assign io_resp_bits_data = buffered ? head : sram_R0_data;
    assign io_busy           = !reset && (inflight || buffered);

    sram_resp_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (sram_R0_data),
        .head      (head),
        .count     (count)
    );

endmodule
